// File: rtl/pcm_rom_pkg.sv
// Shared types and constants for the PCM ROM download-to-DDRAM writer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package pcm_rom_pkg;

  // One DDRAM word carries eight download bytes.
  localparam int LANES      = 8;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = LANES * BYTE_W;
  localparam int LANE_W     = 3;
  localparam int BE_W       = LANES;

  // Address widths of the download bus and of the DDRAM word address.
  localparam int DL_ADDR_W  = 25;
  localparam int DDR_ADDR_W = 29;

  // Word index within the region: the byte offset without its lane bits.
  localparam int WIDX_W     = DL_ADDR_W - LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // accumulating bytes into the held word
    ST_WRITE     = 2'd1,  // DDRAM_WE asserted, waiting for acceptance
    ST_FLUSH_END = 2'd2   // download ended with a partial word still held
  } state_t;

  // Byte lane of a region offset.
  function automatic logic [LANE_W-1:0] lane_of(input logic [DL_ADDR_W-1:0] off);
    return off[LANE_W-1:0];
  endfunction

  // Word index of a region offset.
  function automatic logic [WIDX_W-1:0] widx_of(input logic [DL_ADDR_W-1:0] off);
    return off[DL_ADDR_W-1:LANE_W];
  endfunction

endpackage

// File: rtl/pcm_byte_packer.sv
// Packs in-region download bytes into a 64-bit word with byte enables; one-byte skid.
// Latency: a byte lands in the held word one edge after its strobe (skid bytes one edge after IDLE resumes).
// Backpressure: while the FSM is busy a single strobe is captured in the skid register; a second one is dropped.
module pcm_byte_packer
  import pcm_rom_pkg::*;
#(
  parameter logic [DL_ADDR_W-1:0] REGION_START = 25'h0,
  parameter int                   REGION_SIZE  = 262144
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 i_idle,        // FSM is accumulating
  input  logic                 i_clr,         // held word accepted by DDRAM
  input  logic                 i_dl_active,
  input  logic                 i_dl_wr,
  input  logic [DL_ADDR_W-1:0] i_dl_addr,
  input  logic [BYTE_W-1:0]    i_dl_data,
  output logic [WORD_W-1:0]    o_word,
  output logic [BE_W-1:0]      o_be,
  output logic [WIDX_W-1:0]    o_nxt_widx,    // word index held after this edge
  output logic                 o_skid_vld,
  output logic                 o_conflict,    // new byte belongs to another word
  output logic                 o_land7        // a byte lands in the last lane
);

  logic [WORD_W-1:0]    r_word;
  logic [BE_W-1:0]      r_be;
  logic [WIDX_W-1:0]    r_widx;
  logic                 r_skid_vld;
  logic [DL_ADDR_W-1:0] r_skid_off;
  logic [BYTE_W-1:0]    r_skid_dat;

  logic [31:0]          w_off32;
  logic                 w_hit;
  logic [DL_ADDR_W-1:0] w_dl_off;
  logic                 w_src_vld;
  logic [DL_ADDR_W-1:0] w_src_off;
  logic [BYTE_W-1:0]    w_src_dat;
  logic [WIDX_W-1:0]    w_src_widx;
  logic [LANE_W-1:0]    w_src_lane;
  logic                 w_conflict;
  logic                 w_merge;
  logic                 w_capture;

  // Single unsigned compare covers both bounds: addresses below the region
  // wrap to huge offsets and fail the size test.
  assign w_off32  = {7'd0, i_dl_addr} - {7'd0, REGION_START};
  assign w_hit    = i_dl_active & i_dl_wr & (w_off32 < 32'(REGION_SIZE));
  assign w_dl_off = w_off32[DL_ADDR_W-1:0];

  // A pending skid byte always goes ahead of a live strobe.
  assign w_src_vld  = r_skid_vld | w_hit;
  assign w_src_off  = r_skid_vld ? r_skid_off : w_dl_off;
  assign w_src_dat  = r_skid_vld ? r_skid_dat : i_dl_data;
  assign w_src_widx = widx_of(w_src_off);
  assign w_src_lane = lane_of(w_src_off);

  // A byte for another word forces the held word out first; the byte waits in
  // the skid register meanwhile. A skid byte never conflicts because the word
  // was cleared on the way back to IDLE.
  assign w_conflict = i_idle & w_src_vld & (r_be != '0) & (w_src_widx != r_widx);
  assign w_merge    = i_idle & w_src_vld & ~w_conflict;
  assign w_capture  = w_hit & ~r_skid_vld & (~i_idle | w_conflict);

  assign o_word     = r_word;
  assign o_be       = r_be;
  assign o_nxt_widx = w_merge ? w_src_widx : r_widx;
  assign o_skid_vld = r_skid_vld;
  assign o_conflict = w_conflict;
  assign o_land7    = w_merge & (w_src_lane == LANE_W'(LANES - 1));

  // Held word, byte enables and skid register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_word     <= '0;
      r_be       <= '0;
      r_widx     <= '0;
      r_skid_vld <= 1'b0;
      r_skid_off <= '0;
      r_skid_dat <= '0;
    end else begin
      if (i_clr) begin
        r_word <= '0;
        r_be   <= '0;
      end else if (w_merge) begin
        r_word[{w_src_lane, 3'b000} +: BYTE_W] <= w_src_dat;
        r_be[w_src_lane]                       <= 1'b1;
        r_widx                                 <= w_src_widx;
      end

      if (w_capture) begin
        r_skid_vld <= 1'b1;
        r_skid_off <= w_dl_off;
        r_skid_dat <= i_dl_data;
      end else if (w_merge && r_skid_vld) begin
        r_skid_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcm_rom_writer.sv
// Writes the PCM ROM part of an ioctl download into DDRAM as 64-bit single-beat writes.
// Latency: WE rises the cycle after lane 7 fills (or after a word change / download end) and holds until accepted.
// Backpressure: dl_wait is high while a write is pending or the skid byte is full; DDRAM_BUSY stretches WE.
module pcm_rom_writer
  import pcm_rom_pkg::*;
#(
  parameter logic [DDR_ADDR_W-1:0] BASE_ADDR    = 29'h0300000,
  parameter logic [DL_ADDR_W-1:0]  REGION_START = 25'h0,
  parameter int                    REGION_SIZE  = 262144
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  dl_active,
  input  logic                  dl_wr,
  input  logic [DL_ADDR_W-1:0]  dl_addr,
  input  logic [BYTE_W-1:0]     dl_data,
  output logic                  dl_wait,
  input  logic                  DDRAM_BUSY,
  output logic [DDR_ADDR_W-1:0] DDRAM_ADDR,
  output logic [WORD_W-1:0]     DDRAM_DIN,
  output logic [BE_W-1:0]       DDRAM_BE,
  output logic                  DDRAM_WE,
  output logic [7:0]            DDRAM_BURSTCNT,
  output logic                  loaded
);

  state_t                r_state;
  logic                  r_we;
  logic [DDR_ADDR_W-1:0] r_addr;
  logic                  r_loaded;
  logic                  r_active_d;
  logic                  r_pend_end;   // download ended, final flush not yet done

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_rise;
  logic                  w_fall;
  logic [WORD_W-1:0]     w_word;
  logic [BE_W-1:0]       w_be;
  logic [WIDX_W-1:0]     w_nxt_widx;
  logic                  w_skid_vld;
  logic                  w_conflict;
  logic                  w_land7;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = (r_state == ST_WRITE) & ~DDRAM_BUSY;
  assign w_rise   = dl_active & ~r_active_d;
  assign w_fall   = ~dl_active & r_active_d;

  pcm_byte_packer #(
    .REGION_START (REGION_START),
    .REGION_SIZE  (REGION_SIZE)
  ) u_packer (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .i_idle      (w_idle),
    .i_clr       (w_accept),
    .i_dl_active (dl_active),
    .i_dl_wr     (dl_wr),
    .i_dl_addr   (dl_addr),
    .i_dl_data   (dl_data),
    .o_word      (w_word),
    .o_be        (w_be),
    .o_nxt_widx  (w_nxt_widx),
    .o_skid_vld  (w_skid_vld),
    .o_conflict  (w_conflict),
    .o_land7     (w_land7)
  );

  // Write sequencing, DDRAM address/strobe and the loaded flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_loaded   <= 1'b0;
      r_active_d <= 1'b0;
      r_pend_end <= 1'b0;
    end else begin
      r_active_d <= dl_active;

      // A new download cancels any previous completion; the end of one
      // is remembered until its last word is out.
      if (w_rise) begin
        r_loaded   <= 1'b0;
        r_pend_end <= 1'b0;
      end else if (w_fall) begin
        r_pend_end <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // Address follows the held word so it is already valid when WE rises.
          r_addr <= BASE_ADDR + DDR_ADDR_W'(w_nxt_widx);
          if (w_conflict || w_land7) begin
            r_state <= ST_WRITE;
            r_we    <= 1'b1;
          end else if ((w_fall || r_pend_end) && !dl_active && !w_skid_vld) begin
            if (w_be != '0) begin
              r_state <= ST_FLUSH_END;
            end else begin
              r_loaded   <= 1'b1;
              r_pend_end <= 1'b0;
            end
          end
        end

        ST_FLUSH_END: begin
          r_state <= ST_WRITE;
          r_we    <= 1'b1;
        end

        ST_WRITE: begin
          if (!DDRAM_BUSY) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            // Nothing left behind this word once the download is over.
            if (!dl_active && !w_skid_vld) begin
              r_loaded   <= 1'b1;
              r_pend_end <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

  assign dl_wait        = (r_state != ST_IDLE) | w_skid_vld;
  assign DDRAM_WE       = r_we;
  assign DDRAM_ADDR     = r_addr;
  assign DDRAM_DIN      = w_word;
  assign DDRAM_BE       = w_be;
  assign DDRAM_BURSTCNT = 8'd1;
  assign loaded         = r_loaded;

endmodule

// File: tb/tb_pcm_rom_writer.sv
// Scoreboard bench for pcm_rom_writer: directed scenarios plus randomized downloads.
// Latency: n/a (testbench).
// Backpressure: driver honours dl_wait except where a protocol corner is provoked on purpose.
module tb_pcm_rom_writer;

  localparam logic [28:0] BASE = 29'h0300000;
  localparam logic [24:0] RS   = 25'h0001000;
  localparam int          RSZ  = 4096;

  logic        clk_sys    = 1'b0;
  logic        reset      = 1'b1;
  logic        dl_active  = 1'b0;
  logic        dl_wr      = 1'b0;
  logic [24:0] dl_addr    = '0;
  logic [7:0]  dl_data    = '0;
  logic        dl_wait;
  logic        DDRAM_BUSY;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        loaded;

  logic busy_rand    = 1'b0;
  logic busy_force   = 1'b0;
  logic busy_rnd_val = 1'b0;
  assign DDRAM_BUSY = busy_rand ? busy_rnd_val : busy_force;

  pcm_rom_writer #(
    .BASE_ADDR    (BASE),
    .REGION_START (RS),
    .REGION_SIZE  (RSZ)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .dl_active      (dl_active),
    .dl_wr          (dl_wr),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .dl_wait        (dl_wait),
    .DDRAM_BUSY     (DDRAM_BUSY),
    .DDRAM_ADDR     (DDRAM_ADDR),
    .DDRAM_DIN      (DDRAM_DIN),
    .DDRAM_BE       (DDRAM_BE),
    .DDRAM_WE       (DDRAM_WE),
    .DDRAM_BURSTCNT (DDRAM_BURSTCNT),
    .loaded         (loaded)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  n_writes = 0;
  int  run      = 0;
  int  last_run = 0;
  logic [28:0] run_addr;
  logic [63:0] run_din;
  logic [7:0]  run_be;

  // Reference model: the word currently being assembled from download bytes.
  int          m_widx = 0;
  logic [7:0]  m_be   = '0;
  logic [63:0] m_din  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_push();
    wr_t w;
    w.addr = BASE + 29'(m_widx);
    w.din  = m_din;
    w.be   = m_be;
    exp_q.push_back(w);
    m_be  = '0;
    m_din = '0;
  endtask

  // A byte in the region goes to word off/8, lane off%8; a full word or a
  // byte for a different word sends the current word out.
  task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
    int off, widx, lane;
    off = int'(a) - int'(RS);
    if (!dl_active || off < 0 || off >= RSZ) return;
    widx = off / 8;
    lane = off % 8;
    if (m_be != 0 && widx != m_widx) model_push();
    m_widx            = widx;
    m_din[lane*8 +: 8] = d;
    m_be[lane]        = 1'b1;
    if (lane == 7) model_push();
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int i;
    i = 0;
    while (dl_wait && i < 200) begin
      tick();
      i++;
    end
    if (dl_wait) begin
      check("send_wait_timeout", 64'(dl_wait), 64'd0);
      return;
    end
    model_byte(a, d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    tick();
    dl_wr   = 1'b0;
  endtask

  // Strobe regardless of dl_wait.
  task automatic send_raw(input logic [24:0] a, input logic [7:0] d);
    model_byte(a, d);
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic end_download();
    dl_active = 1'b0;
    if (m_be != 0) model_push();
    tick();
  endtask

  task automatic wait_loaded(input string name);
    for (int i = 0; i < 400; i++) begin
      if (loaded) break;
      tick();
    end
    check(name, 64'(loaded), 64'd1);
  endtask

  always @(posedge clk_sys) begin
    #1;
    busy_rnd_val = ($urandom_range(0, 2) == 0);
  end

  // Monitor: every accepted write is popped from the scoreboard and compared.
  always @(negedge clk_sys) begin
    if (reset) begin
      run = 0;
    end else if (DDRAM_WE) begin
      check("wait_during_we", 64'(dl_wait), 64'd1);
      if (run > 0) begin
        check("din_stable", DDRAM_DIN, run_din);
        check("addr_stable", 64'(DDRAM_ADDR), 64'(run_addr));
        check("be_stable", 64'(DDRAM_BE), 64'(run_be));
      end
      run++;
      run_addr = DDRAM_ADDR;
      run_din  = DDRAM_DIN;
      run_be   = DDRAM_BE;
      if (!DDRAM_BUSY) begin
        n_writes++;
        check("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        check("addr_in_range",
              64'((DDRAM_ADDR >= BASE) && (DDRAM_ADDR < BASE + 29'(RSZ / 8))), 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(DDRAM_ADDR), 64'h1FFFFFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(DDRAM_ADDR), 64'(e.addr));
          check("wr_din", DDRAM_DIN, e.din);
          check("wr_be", 64'(DDRAM_BE), 64'(e.be));
        end
      end
    end else if (run != 0) begin
      last_run = run;
      run      = 0;
    end
  end

  initial begin
    int nw;
    int a;
    int p;

    // Reset values
    repeat (3) tick();
    check("rst_we", 64'(DDRAM_WE), 64'd0);
    check("rst_be", 64'(DDRAM_BE), 64'd0);
    check("rst_din", DDRAM_DIN, 64'd0);
    check("rst_addr", 64'(DDRAM_ADDR), 64'(BASE));
    check("rst_wait", 64'(dl_wait), 64'd0);
    check("rst_loaded", 64'(loaded), 64'd0);
    check("rst_burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    reset = 1'b0;
    tick();

    // Eight bytes, DDRAM idle: one single-cycle write
    dl_active = 1'b1;
    tick();
    nw = n_writes;
    for (int i = 0; i < 8; i++) send_byte(RS + 25'(i), 8'(i));
    repeat (4) tick();
    check("full_word_writes", 64'(n_writes - nw), 64'd1);
    check("full_word_we_len", 64'(last_run), 64'd1);

    // Same word with DDRAM busy for five cycles: WE held six cycles
    busy_force = 1'b1;
    nw = n_writes;
    for (int i = 0; i < 8; i++) send_byte(RS + 25'(i), 8'(i));
    check("busy_we_rise", 64'(DDRAM_WE), 64'd1);
    repeat (5) tick();
    busy_force = 1'b0;
    repeat (3) tick();
    check("busy_we_len", 64'(last_run), 64'd6);
    check("busy_writes", 64'(n_writes - nw), 64'd1);

    // Partial word flushed at download end
    send_byte(RS + 25'd8, 8'hAA);
    send_byte(RS + 25'd9, 8'hBB);
    send_byte(RS + 25'd10, 8'hCC);
    end_download();
    check("partial_loaded_early", 64'(loaded), 64'd0);
    check("partial_flush_wait", 64'(dl_wait), 64'd1);
    wait_loaded("partial_loaded");
    check("partial_queue_empty", 64'(exp_q.size()), 64'd0);

    // Strobes outside the region or outside a download are ignored
    nw = n_writes;
    send_byte(RS + 25'd16, 8'h99);
    dl_active = 1'b1;
    tick();
    check("loaded_clear_on_rise", 64'(loaded), 64'd0);
    send_byte(RS + 25'(RSZ), 8'h11);
    send_byte(RS - 25'd1, 8'h22);
    repeat (3) tick();
    check("oor_be", 64'(DDRAM_BE), 64'd0);
    check("oor_writes", 64'(n_writes - nw), 64'd0);

    // Strobe during a stalled write lands in the skid byte and is not lost
    busy_force = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(RS + 25'(i), 8'(8'h10 + i));
    send_raw(RS + 25'd8, 8'h55);
    check("skid_wait", 64'(dl_wait), 64'd1);
    repeat (2) tick();
    busy_force = 1'b0;
    repeat (4) tick();
    check("skid_be", 64'(DDRAM_BE), 64'h01);
    check("skid_din", DDRAM_DIN, 64'h55);
    check("skid_wait_clear", 64'(dl_wait), 64'd0);
    end_download();
    wait_loaded("skid_loaded");
    check("skid_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a stalled write discards word and skid byte
    dl_active = 1'b1;
    tick();
    busy_force = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(RS + 25'(i), 8'(8'h20 + i));
    send_raw(RS + 25'd8, 8'h66);
    check("rstw_we_before", 64'(DDRAM_WE), 64'd1);
    nw = n_writes;
    reset     = 1'b1;
    dl_active = 1'b0;
    tick();
    check("rstw_we", 64'(DDRAM_WE), 64'd0);
    check("rstw_wait", 64'(dl_wait), 64'd0);
    exp_q.delete();
    m_be  = '0;
    m_din = '0;
    reset      = 1'b0;
    busy_force = 1'b0;
    repeat (10) tick();
    check("rstw_no_write", 64'(n_writes - nw), 64'd0);
    check("rstw_be", 64'(DDRAM_BE), 64'd0);

    // Randomized downloads with random DDRAM stalls
    busy_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      dl_active = 1'b1;
      tick();
      a = int'(RS) + int'($urandom_range(0, RSZ - 1));
      for (int n = 0; n < 150; n++) begin
        p = int'($urandom_range(0, 9));
        if (p < 7) begin
          a = a + 1;
          if (a >= int'(RS) + RSZ || a < int'(RS)) a = int'(RS);
        end else if (p < 9) begin
          a = int'(RS) + int'($urandom_range(0, RSZ - 1));
        end else if ($urandom_range(0, 1) == 0) begin
          a = int'(RS) - 1 - int'($urandom_range(0, 15));
        end else begin
          a = int'(RS) + RSZ + int'($urandom_range(0, 15));
        end
        send_byte(25'(a), 8'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
      end
      end_download();
      wait_loaded("rand_loaded");
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    end
    busy_rand = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcm_rom_writer.md
PCM_ROM_WRITER -- requirements
Module: pcm_rom_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 29'h0300000; DDRAM 64-bit word address of the PCM ROM image.
REQ-002 SHALL have parameter REGION_START, default 25'h0; first download byte address belonging to the PCM ROM.
REQ-003 SHALL have parameter REGION_SIZE, default 262144; PCM ROM size in bytes, a multiple of 8.
REQ-004 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port dl_active  in  1  download of the matching ioctl index in progress.
REQ-007 SHALL have port dl_wr  in  1  one-cycle byte strobe.
REQ-008 SHALL have port dl_addr  in  25  byte address of dl_data.
REQ-009 SHALL have port dl_data  in  8  download byte.
REQ-010 SHALL have port dl_wait  out  1  stall request to the download source.
REQ-011 SHALL have DDRAM ports: DDRAM_BUSY in 1, DDRAM_ADDR out 29, DDRAM_DIN out 64, DDRAM_BE out 8, DDRAM_WE out 1, DDRAM_BURSTCNT out 8.
REQ-012 SHALL have port loaded  out  1  PCM image completely written.

Function
REQ-013 SHALL ignore dl_wr when dl_active=0 or dl_addr is outside [REGION_START, REGION_START+REGION_SIZE).
REQ-014 SHALL compute off = dl_addr-REGION_START, then place the byte in lane off[2:0], bits [8*lane+7 : 8*lane], and set BE bit lane.
REQ-015 SHALL write to word address BASE_ADDR + off[17:3], matching the reader's ddram_data[(addr[2:0]*8)+:8] selection.
REQ-016 SHALL use states IDLE (accumulating), WRITE (WE asserted), FLUSH_END (final partial word).
REQ-017 SHALL start a flush (IDLE->WRITE) on the cycle after a byte lands in lane 7.
REQ-018 SHALL flush the held word first when an in-region byte arrives for a different word with BE != 0; that byte is then held in the skid register.
REQ-019 SHALL go IDLE->FLUSH_END->WRITE on the cycle dl_active falls while BE != 0.
REQ-020 In WRITE: SHALL hold DDRAM_WE=1 with ADDR/DIN/BE stable; the write is accepted on the edge where WE=1 and DDRAM_BUSY=0; the next state is IDLE with DIN and BE cleared.
REQ-021 SHALL hold dl_wait=1 in WRITE and FLUSH_END, and while the skid register is full; it SHALL be 0 otherwise.
REQ-022 SHALL provide a one-byte skid register that captures a dl_wr arriving in WRITE; on return to IDLE it is merged as a fresh byte before any new dl_wr; a second dl_wr while the skid register is full is a protocol violation and is dropped.
REQ-023 DDRAM_BURSTCNT SHALL be constant 8'd1.
REQ-024 loaded SHALL go to 1 when dl_active=0 and the final write is accepted, or immediately at dl_active fall if BE=0; it SHALL clear on the cycle dl_active rises.
REQ-025 SHALL never write outside BASE_ADDR .. BASE_ADDR+REGION_SIZE/8-1.

Reset
REQ-026 On reset=1 at a clock edge: state IDLE, DDRAM_WE=0, DIN=0, BE=0, ADDR=BASE_ADDR, dl_wait=0, loaded=0, skid register empty.
REQ-027 Reset mid-WRITE SHALL drop WE on the next edge and discard the pending word and the skid byte.

Structure
REQ-028 Package pcm_rom_pkg SHALL hold the state enum, LANES=8, and the word/byte width constants.
REQ-029 One sub-module, pcm_byte_packer (lane placement, BE accumulation, skid register), is natural; the FSM and DDRAM port drive stay in pcm_rom_writer.

Verification
REQ-030 Bytes 0x00..0x07 at REGION_START, DDRAM_BUSY=0 -> one WE pulse, ADDR=BASE_ADDR, DIN=64'h0706050403020100, BE=8'hFF.
REQ-031 Same stimulus with DDRAM_BUSY=1 for 5 cycles -> WE high for 6 cycles, DIN stable, dl_wait=1 throughout.
REQ-032 3 bytes AA,BB,CC at offsets 8..10, then dl_active falls -> one write, ADDR=BASE_ADDR+1, BE=8'h07, DIN[23:0]=CCBBAA; loaded=1 after acceptance.
REQ-033 Bytes at REGION_START+REGION_SIZE and REGION_START-1 -> no WE, BE stays 0.
REQ-034 dl_wr with data 0x55 at offset 8 during WRITE with BUSY=1 -> byte held in the skid register, later written at lane 0 of BASE_ADDR+1, no loss.
REQ-035 reset asserted while WE=1 and BUSY=1 -> WE=0 and dl_wait=0 the next cycle, and no write occurs afterwards.
